reservation_station: RTL and testbench

Reservation station sitting directly downstream of the current-instruction stage in the Tomasulo core. Accepts one issued instruction per cycle (operator, two operand values/tags), allocates an entry and returns that entry's tag for the register-bank rename. Snoops the CDB to capture pending operands and dispatches ready instructions to one functional unit over a valid/ready handshake. An entry stays occupied until its own tag appears on the CDB, so a tag is never reused while its result is still outstanding.

---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/rs_entry.sv | 100 ++++++++++
 rtl/reservation_station.sv | 136 +++++++++++++
 tb/tb_reservation_station.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared types and widths for the Tomasulo core: tag/data/op widths,
// the "operand value is valid" tag marker and the reservation-entry state encoding.
package tomasulo_pkg;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 5;

    localparam logic [TAG_W-1:0] INVALID_TAG = 5'b11111;

    typedef enum logic [1:0] {
        FREE,
        WAIT,
        READY,
        EXEC
    } entry_state_t;
endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: lifecycle FSM, operand capture with CDB snoop and issue bypass.
// Optional RS_OLDEST_FIRST_EN adds a saturating age counter used by the top for oldest-first dispatch.
//
// state | meaning
// FREE  | slot unused, may be allocated
// WAIT  | at least one operand still waiting on a CDB tag
// READY | both operands valid, candidate for dispatch
// EXEC  | in/through the dispatch register, held until own tag seen on CDB
module rs_entry
    import tomasulo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef RS_OLDEST_FIRST_EN
    output logic [2:0]        age,
`endif
    input  logic [TAG_W-1:0]  my_tag,
    input  logic              alloc,
    input  logic [OP_W-1:0]   iss_op,
    input  logic [DATA_W-1:0] iss_val_1,
    input  logic [DATA_W-1:0] iss_val_2,
    input  logic [TAG_W-1:0]  iss_tag_1,
    input  logic [TAG_W-1:0]  iss_tag_2,
    input  logic              select,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_val,
    output entry_state_t      state,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] val_1,
    output logic [DATA_W-1:0] val_2
);
    logic [TAG_W-1:0]  tag_1, tag_2;
    logic [TAG_W-1:0]  nxt_tag_1, nxt_tag_2;
    logic [DATA_W-1:0] nxt_val_1, nxt_val_2;
    logic              cdb_live, operands_ready;

    assign cdb_live = cdb_valid && (cdb_tag != INVALID_TAG);

    // The same compare serves both issue bypass (fresh source fields) and WAIT capture.
    always_comb begin
        nxt_tag_1 = alloc ? iss_tag_1 : tag_1;
        nxt_val_1 = alloc ? iss_val_1 : val_1;
        nxt_tag_2 = alloc ? iss_tag_2 : tag_2;
        nxt_val_2 = alloc ? iss_val_2 : val_2;
        if (cdb_live && (nxt_tag_1 == cdb_tag)) begin
            nxt_tag_1 = INVALID_TAG;
            nxt_val_1 = cdb_val;
        end
        if (cdb_live && (nxt_tag_2 == cdb_tag)) begin
            nxt_tag_2 = INVALID_TAG;
            nxt_val_2 = cdb_val;
        end
        operands_ready = (nxt_tag_1 == INVALID_TAG) && (nxt_tag_2 == INVALID_TAG);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
            op    <= '0;
            tag_1 <= INVALID_TAG;
            tag_2 <= INVALID_TAG;
            val_1 <= '0;
            val_2 <= '0;
        end else begin
            case (state)
                FREE: if (alloc) begin
                    op    <= iss_op;
                    tag_1 <= nxt_tag_1;
                    tag_2 <= nxt_tag_2;
                    val_1 <= nxt_val_1;
                    val_2 <= nxt_val_2;
                    state <= operands_ready ? READY : WAIT;
                end
                WAIT: begin
                    tag_1 <= nxt_tag_1;
                    tag_2 <= nxt_tag_2;
                    val_1 <= nxt_val_1;
                    val_2 <= nxt_val_2;
                    if (operands_ready) state <= READY;
                end
                READY: if (select) state <= EXEC;
                EXEC: if (cdb_live && (cdb_tag == my_tag)) state <= FREE;
                default: state <= FREE;
            endcase
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (state == FREE) begin
            age <= '0;
        end else if (age != 3'd7) begin
            age <= age + 3'd1;
        end
    end
`endif
endmodule

// File: rtl/reservation_station.sv
// Reservation station top: lowest-free allocation, ready select, dispatch register and occupancy.
// Define RS_OLDEST_FIRST_EN for oldest-first dispatch; otherwise lowest-index READY entry wins.
module reservation_station
    import tomasulo_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_BASE    = 0
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_issue_valid,
    input  logic [OP_W-1:0]   in_issue_op,
    input  logic [DATA_W-1:0] in_issue_val_1,
    input  logic [DATA_W-1:0] in_issue_val_2,
    input  logic [TAG_W-1:0]  in_issue_tag_1,
    input  logic [TAG_W-1:0]  in_issue_tag_2,
    output logic              out_issue_ready,
    output logic              out_alloc_valid,
    output logic [TAG_W-1:0]  out_alloc_tag,
    input  logic              in_cdb_valid,
    input  logic [TAG_W-1:0]  in_cdb_tag,
    input  logic [DATA_W-1:0] in_cdb_val,
    output logic              out_disp_valid,
    output logic [OP_W-1:0]   out_disp_op,
    output logic [DATA_W-1:0] out_disp_val_1,
    output logic [DATA_W-1:0] out_disp_val_2,
    output logic [TAG_W-1:0]  out_disp_tag,
    input  logic              in_disp_ready,
    output logic [3:0]        out_count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    entry_state_t      ent_state [NUM_ENTRIES];
    logic [OP_W-1:0]   ent_op    [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_val_1 [NUM_ENTRIES];
    logic [DATA_W-1:0] ent_val_2 [NUM_ENTRIES];
`ifdef RS_OLDEST_FIRST_EN
    logic [2:0]        ent_age   [NUM_ENTRIES];
    logic [2:0]        sel_age;
`endif

    logic             free_found, ready_found, accept, disp_load;
    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic [3:0]       occ_count;

    // Descending scan so the lowest FREE index is the last one written.
    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        occ_count  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_state[i] == FREE) begin
                free_found = 1'b1;
                alloc_idx  = IDX_W'(i);
            end else begin
                occ_count = occ_count + 4'd1;
            end
        end
    end

    always_comb begin
        ready_found = 1'b0;
        sel_idx     = '0;
`ifdef RS_OLDEST_FIRST_EN
        sel_age = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if ((ent_state[i] == READY) && (!ready_found || (ent_age[i] > sel_age))) begin
                ready_found = 1'b1;
                sel_idx     = IDX_W'(i);
                sel_age     = ent_age[i];
            end
        end
`else
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_state[i] == READY) begin
                ready_found = 1'b1;
                sel_idx     = IDX_W'(i);
            end
        end
`endif
    end

    assign out_issue_ready = free_found;
    assign out_count       = occ_count;
    assign accept          = in_issue_valid && free_found;
    assign disp_load       = ready_found && (!out_disp_valid || in_disp_ready);

    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
        rs_entry u_entry (
            .clk       (clk),
            .rst       (rst),
`ifdef RS_OLDEST_FIRST_EN
            .age       (ent_age[i]),
`endif
            .my_tag    (TAG_W'(TAG_BASE + i)),
            .alloc     (accept && (alloc_idx == IDX_W'(i))),
            .iss_op    (in_issue_op),
            .iss_val_1 (in_issue_val_1),
            .iss_val_2 (in_issue_val_2),
            .iss_tag_1 (in_issue_tag_1),
            .iss_tag_2 (in_issue_tag_2),
            .select    (disp_load && (sel_idx == IDX_W'(i))),
            .cdb_valid (in_cdb_valid),
            .cdb_tag   (in_cdb_tag),
            .cdb_val   (in_cdb_val),
            .state     (ent_state[i]),
            .op        (ent_op[i]),
            .val_1     (ent_val_1[i]),
            .val_2     (ent_val_2[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_alloc_valid <= 1'b0;
            out_alloc_tag   <= INVALID_TAG;
            out_disp_valid  <= 1'b0;
            out_disp_op     <= '0;
            out_disp_val_1  <= '0;
            out_disp_val_2  <= '0;
            out_disp_tag    <= '0;
        end else begin
            out_alloc_valid <= accept;
            if (accept) out_alloc_tag <= TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
            if (disp_load) begin
                out_disp_valid <= 1'b1;
                out_disp_op    <= ent_op[sel_idx];
                out_disp_val_1 <= ent_val_1[sel_idx];
                out_disp_val_2 <= ent_val_2[sel_idx];
                out_disp_tag   <= TAG_W'(TAG_BASE) + TAG_W'(sel_idx);
            end else if (in_disp_ready) begin
                out_disp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (4 entries, tags 0..3).
module tb_reservation_station;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_issue_valid;
    logic [4:0]  in_issue_op;
    logic [31:0] in_issue_val_1, in_issue_val_2;
    logic [4:0]  in_issue_tag_1, in_issue_tag_2;
    logic        out_issue_ready, out_alloc_valid;
    logic [4:0]  out_alloc_tag;
    logic        in_cdb_valid;
    logic [4:0]  in_cdb_tag;
    logic [31:0] in_cdb_val;
    logic        out_disp_valid;
    logic [4:0]  out_disp_op;
    logic [31:0] out_disp_val_1, out_disp_val_2;
    logic [4:0]  out_disp_tag;
    logic        in_disp_ready;
    logic [3:0]  out_count;

    int n_checks = 0;
    int n_fail   = 0;

    reservation_station #(.NUM_ENTRIES(4), .TAG_BASE(0)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_issue_valid  (in_issue_valid),
        .in_issue_op     (in_issue_op),
        .in_issue_val_1  (in_issue_val_1),
        .in_issue_val_2  (in_issue_val_2),
        .in_issue_tag_1  (in_issue_tag_1),
        .in_issue_tag_2  (in_issue_tag_2),
        .out_issue_ready (out_issue_ready),
        .out_alloc_valid (out_alloc_valid),
        .out_alloc_tag   (out_alloc_tag),
        .in_cdb_valid    (in_cdb_valid),
        .in_cdb_tag      (in_cdb_tag),
        .in_cdb_val      (in_cdb_val),
        .out_disp_valid  (out_disp_valid),
        .out_disp_op     (out_disp_op),
        .out_disp_val_1  (out_disp_val_1),
        .out_disp_val_2  (out_disp_val_2),
        .out_disp_tag    (out_disp_tag),
        .in_disp_ready   (in_disp_ready),
        .out_count       (out_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] v1, input logic [4:0] t1,
                         input logic [31:0] v2, input logic [4:0] t2);
        in_issue_valid = 1'b1;
        in_issue_op    = op;
        in_issue_val_1 = v1;
        in_issue_tag_1 = t1;
        in_issue_val_2 = v2;
        in_issue_tag_2 = t2;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] v);
        in_cdb_valid = 1'b1;
        in_cdb_tag   = t;
        in_cdb_val   = v;
    endtask

    initial begin
        rst = 1'b1;
        in_issue_valid = 1'b0; in_issue_op = '0;
        in_issue_val_1 = '0; in_issue_val_2 = '0;
        in_issue_tag_1 = 5'h1f; in_issue_tag_2 = 5'h1f;
        in_cdb_valid = 1'b0; in_cdb_tag = 5'h1f; in_cdb_val = '0;
        in_disp_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();

        chk("rst_issue_ready", 32'(out_issue_ready), 32'd1);
        chk("rst_count",       32'(out_count), 32'd0);
        chk("rst_disp_valid",  32'(out_disp_valid), 32'd0);
        chk("rst_alloc_valid", 32'(out_alloc_valid), 32'd0);
        chk("rst_alloc_tag",   32'(out_alloc_tag), 32'h1f);
        chk("rst_disp_op",     32'(out_disp_op), 32'd0);

        // Ready operands: alloc pulse after edge N, dispatch after N+1.
        issue(5'd3, 32'd10, 5'h1f, 32'd20, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t1_alloc_valid", 32'(out_alloc_valid), 32'd1);
        chk("t1_alloc_tag",   32'(out_alloc_tag), 32'd0);
        chk("t1_count",       32'(out_count), 32'd1);
        chk("t1_disp_early",  32'(out_disp_valid), 32'd0);
        tick();
        chk("t1_disp_valid",  32'(out_disp_valid), 32'd1);
        chk("t1_disp_op",     32'(out_disp_op), 32'd3);
        chk("t1_disp_val_1",  out_disp_val_1, 32'd10);
        chk("t1_disp_val_2",  out_disp_val_2, 32'd20);
        chk("t1_disp_tag",    32'(out_disp_tag), 32'd0);
        chk("t1_alloc_pulse", 32'(out_alloc_valid), 32'd0);
        cdb(5'd0, 32'd99);
        tick();
        in_cdb_valid = 1'b0;
        chk("t1_freed_count", 32'(out_count), 32'd0);
        chk("t1_disp_drained", 32'(out_disp_valid), 32'd0);

        // Pending operand captured from CDB.
        issue(5'd4, 32'd0, 5'd2, 32'd5, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t2_alloc_tag", 32'(out_alloc_tag), 32'd0);
        tick();
        chk("t2_wait_no_disp", 32'(out_disp_valid), 32'd0);
        cdb(5'd2, 32'hABCD);
        tick();
        in_cdb_valid = 1'b0;
        chk("t2_ready_no_disp", 32'(out_disp_valid), 32'd0);
        tick();
        chk("t2_disp_valid", 32'(out_disp_valid), 32'd1);
        chk("t2_disp_val_1", out_disp_val_1, 32'hABCD);
        chk("t2_disp_val_2", out_disp_val_2, 32'd5);
        cdb(5'd0, 32'd1);
        tick();
        in_cdb_valid = 1'b0;
        chk("t2_freed_count", 32'(out_count), 32'd0);

        // Issue/CDB bypass on operand 2.
        issue(5'd6, 32'd1, 5'h1f, 32'd0, 5'd5);
        cdb(5'd5, 32'd7);
        tick();
        in_issue_valid = 1'b0;
        in_cdb_valid = 1'b0;
        chk("t3_alloc_tag", 32'(out_alloc_tag), 32'd0);
        tick();
        chk("t3_disp_valid", 32'(out_disp_valid), 32'd1);
        chk("t3_disp_op",    32'(out_disp_op), 32'd6);
        chk("t3_disp_val_2", out_disp_val_2, 32'd7);
        cdb(5'd0, 32'd1);
        tick();
        in_cdb_valid = 1'b0;
        chk("t3_freed_count", 32'(out_count), 32'd0);

        // Fill all four entries with the functional unit stalled.
        in_disp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue(5'(10 + k), 32'(100 + k), 5'h1f, 32'(200 + k), 5'h1f);
            tick();
            chk("t4_alloc_tag", 32'(out_alloc_tag), 32'(k));
        end
        chk("t4_full_ready", 32'(out_issue_ready), 32'd0);
        chk("t4_full_count", 32'(out_count), 32'd4);
        issue(5'd14, 32'd1, 5'h1f, 32'd1, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t4_full_no_alloc", 32'(out_alloc_valid), 32'd0);
        chk("t4_full_count2",   32'(out_count), 32'd4);
        chk("t4_disp_tag",      32'(out_disp_tag), 32'd0);

        // Stalled dispatch register holds its contents.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_hold_op",    32'(out_disp_op), 32'd10);
            chk("t5_hold_val_1", out_disp_val_1, 32'd100);
            chk("t5_hold_val_2", out_disp_val_2, 32'd200);
        end
        in_disp_ready = 1'b1;
        tick();
        in_disp_ready = 1'b0;
        chk("t5_next_tag",   32'(out_disp_tag), 32'd1);
        chk("t5_next_op",    32'(out_disp_op), 32'd11);
        chk("t5_next_val_1", out_disp_val_1, 32'd101);

        // Free entry 0 via its own broadcast, then reallocate it.
        cdb(5'd0, 32'd55);
        tick();
        in_cdb_valid = 1'b0;
        chk("t4_realloc_ready", 32'(out_issue_ready), 32'd1);
        chk("t4_realloc_count", 32'(out_count), 32'd3);
        issue(5'd15, 32'd3, 5'h1f, 32'd4, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t4_realloc_tag",   32'(out_alloc_tag), 32'd0);
        chk("t4_realloc_valid", 32'(out_alloc_valid), 32'd1);

        // Mid-operation reset discards everything.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_count",       32'(out_count), 32'd0);
        chk("mr_disp_valid",  32'(out_disp_valid), 32'd0);
        chk("mr_issue_ready", 32'(out_issue_ready), 32'd1);
        chk("mr_alloc_tag",   32'(out_alloc_tag), 32'h1f);

        // Entry 2 issued before entry 0 is reallocated; both READY when the FU frees up.
        issue(5'd20, 32'd1, 5'h1f, 32'd2, 5'h1f);
        tick();
        issue(5'd21, 32'd0, 5'd9, 32'd0, 5'h1f);
        tick();
        issue(5'd22, 32'd5, 5'h1f, 32'd6, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t6_alloc_tag2", 32'(out_alloc_tag), 32'd2);
        cdb(5'd0, 32'd0);
        tick();
        in_cdb_valid = 1'b0;
        issue(5'd23, 32'd7, 5'h1f, 32'd8, 5'h1f);
        tick();
        in_issue_valid = 1'b0;
        chk("t6_alloc_tag0", 32'(out_alloc_tag), 32'd0);
        chk("t6_held_op",    32'(out_disp_op), 32'd20);
        in_disp_ready = 1'b1;
        tick();
`ifdef RS_OLDEST_FIRST_EN
        chk("t6_sel_tag", 32'(out_disp_tag), 32'd2);
        chk("t6_sel_op",  32'(out_disp_op), 32'd22);
`else
        chk("t6_sel_tag", 32'(out_disp_tag), 32'd0);
        chk("t6_sel_op",  32'(out_disp_op), 32'd23);
`endif
        tick();
`ifdef RS_OLDEST_FIRST_EN
        chk("t6_second_tag", 32'(out_disp_tag), 32'd0);
`else
        chk("t6_second_tag", 32'(out_disp_tag), 32'd2);
`endif
        chk("t6_second_valid", 32'(out_disp_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
